// File: rtl/scalar_wb_arbiter_pkg.sv
// Shared types and default widths for the scalar write-back arbiter.
package asip_pkg;

  localparam int unsigned RegisterSizeDef     = 8;
  localparam int unsigned RegisterQuantityDef = 4;
  localparam int unsigned SelectionBitsDef    = 2;
  localparam int unsigned FifoDepthDef        = 4;
  localparam int unsigned StarveLimitDef      = 3;

  typedef struct packed {
    logic [SelectionBitsDef-1:0] reg_idx;
    logic [RegisterSizeDef-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/scalar_wb_arbiter_if.sv
// ALU result, load return and register-file write signals of the write-back arbiter.
interface scalar_wb_arbiter_if #(
  parameter int unsigned registerSize     = asip_pkg::RegisterSizeDef,
  parameter int unsigned registerQuantity = asip_pkg::RegisterQuantityDef,
  parameter int unsigned selectionBits    = asip_pkg::SelectionBitsDef
);

  logic                        aluValid;
  logic                        aluReady;
  logic [selectionBits-1:0]    aluReg;
  logic [registerSize-1:0]     aluData;
  logic                        memValid;
  logic                        memReady;
  logic [selectionBits-1:0]    memReg;
  logic [registerSize-1:0]     memData;
  logic                        regWrEn;
  logic [selectionBits-1:0]    regToWrite;
  logic [registerSize-1:0]     dataIn;
  logic [registerQuantity-1:0] pendingMask;

  modport master (
    output aluValid, aluReg, aluData, memValid, memReg, memData,
    input  aluReady, memReady, regWrEn, regToWrite, dataIn, pendingMask
  );

  modport slave (
    input  aluValid, aluReg, aluData, memValid, memReg, memData,
    output aluReady, memReady, regWrEn, regToWrite, dataIn, pendingMask
  );

endinterface

// File: rtl/wb_fifo.sv
// Load-return buffer: in-order FIFO that also exposes each slot's register index and validity.
module wb_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned IdxW  = 2,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [Width-1:0]            wdata_i,
  output logic [Width-1:0]            rdata_o,
  output logic                        empty_o,
  output logic [CntW-1:0]             count_o,
  output logic [Depth-1:0][IdxW-1:0]  entry_idx_o,
  output logic [Depth-1:0]            valid_o
);

  logic [Depth-1:0][Width-1:0] mem_q;
  logic [PtrW-1:0]             rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]             count_q;
  logic                        do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && (count_q != CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the wrap.
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    logic [PtrW-1:0] offset;
    valid_o     = '0;
    entry_idx_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      offset         = PtrW'(i) - rd_ptr_q;
      valid_o[i]     = CntW'(offset) < count_q;
      entry_idx_o[i] = mem_q[i][Width-1 -: IdxW];
    end
  end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Arbitrates ALU results and load returns onto the single scalar register-file write port.
module scalar_wb_arbiter
  import asip_pkg::*;
#(
  parameter int unsigned registerSize     = RegisterSizeDef,
  parameter int unsigned registerQuantity = RegisterQuantityDef,
  parameter int unsigned selectionBits    = SelectionBitsDef,
  parameter int unsigned fifoDepth        = FifoDepthDef,
  parameter int unsigned starveLimit      = StarveLimitDef
) (
  input logic                 clk,
  input logic                 reset,
  scalar_wb_arbiter_if.slave  bus
);

  localparam int unsigned EntryW  = selectionBits + registerSize;
  localparam int unsigned CntW    = $clog2(fifoDepth + 1);
  localparam int unsigned StarveW = (starveLimit > 0) ? $clog2(starveLimit + 1) : 1;

  logic                                fifo_empty, push, pop;
  logic [CntW-1:0]                     fifo_count;
  logic [EntryW-1:0]                   head;
  logic [fifoDepth-1:0][selectionBits-1:0] entry_idx;
  logic [fifoDepth-1:0]                entry_valid;

  logic [StarveW-1:0]       starve_q;
  logic                     reg_wr_en_q;
  logic [selectionBits-1:0] reg_q, sel_reg;
  logic [registerSize-1:0]  data_q, sel_data;
  logic                     forced, alu_xfer, mem_xfer, win_alu, win_head, win_bypass;

  wb_fifo #(
    .Width (EntryW),
    .IdxW  (selectionBits),
    .Depth (fifoDepth)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .wdata_i     ({bus.memReg, bus.memData}),
    .rdata_o     (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .entry_idx_o (entry_idx),
    .valid_o     (entry_valid)
  );

  always_comb begin
    forced       = !fifo_empty && (starve_q == StarveW'(starveLimit));
    bus.aluReady = !forced;
    bus.memReady = fifo_count < CntW'(fifoDepth);
    alu_xfer     = bus.aluValid && !forced;
    mem_xfer     = bus.memValid && bus.memReady;
    // Forced drain, then ALU, then buffer head, then a load straight past an empty buffer.
    win_head     = forced || (!alu_xfer && !fifo_empty);
    win_alu      = alu_xfer;
    win_bypass   = fifo_empty && !alu_xfer && mem_xfer;
    pop          = win_head;
    push         = mem_xfer && !win_bypass;

    sel_reg  = reg_q;
    sel_data = data_q;
    if (win_head) begin
      sel_reg  = head[EntryW-1 -: selectionBits];
      sel_data = head[registerSize-1:0];
    end else if (win_alu) begin
      sel_reg  = bus.aluReg;
      sel_data = bus.aluData;
    end else if (win_bypass) begin
      sel_reg  = bus.memReg;
      sel_data = bus.memData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_wr_en_q <= 1'b0;
      reg_q       <= '0;
      data_q      <= '0;
      starve_q    <= '0;
    end else begin
      reg_wr_en_q <= win_head || win_alu || win_bypass;
      reg_q       <= sel_reg;
      data_q      <= sel_data;
      if (pop || fifo_empty) starve_q <= '0;
      else if (alu_xfer)     starve_q <= starve_q + StarveW'(1);
    end
  end

  assign bus.regWrEn    = reg_wr_en_q;
  assign bus.regToWrite = reg_q;
  assign bus.dataIn     = data_q;

  always_comb begin
    bus.pendingMask = '0;
    for (int unsigned i = 0; i < fifoDepth; i++) begin
      if (entry_valid[i] && (32'(entry_idx[i]) < registerQuantity)) begin
        bus.pendingMask[entry_idx[i]] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_scalar_wb_arbiter;
  import asip_pkg::*;

  localparam int RS = 8, RQ = 4, SB = 2, FD = 4, SL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scalar_wb_arbiter_if #(.registerSize(RS), .registerQuantity(RQ), .selectionBits(SB)) bus ();

  scalar_wb_arbiter #(
    .registerSize(RS), .registerQuantity(RQ), .selectionBits(SB),
    .fifoDepth(FD), .starveLimit(SL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0, bad = 0;

  // Reference model: buffer as a queue, starvation as a plain count of ALU wins.
  wb_entry_t q[$];
  int        starve;
  logic      m_wr;
  logic [1:0] m_reg;
  logic [7:0] m_data;
  logic      m_alu_ready, m_mem_ready, m_alu_acc, m_mem_acc;
  logic [3:0] m_mask;
  logic      obs_alu_ready, obs_mem_ready;
  logic [3:0] obs_mask;

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_wr = 1'b0; m_reg = '0; m_data = '0;
  endtask

  task automatic set_in(input logic av, input logic [1:0] ar, input logic [7:0] ad,
                        input logic mv, input logic [1:0] mr, input logic [7:0] md);
    bus.aluValid = av; bus.aluReg = ar; bus.aluData = ad;
    bus.memValid = mv; bus.memReg = mr; bus.memData = md;
  endtask

  // One clock: observe combinational outputs, predict, then advance the model past the edge.
  task automatic cycle();
    wb_entry_t alu_e, mem_e, e;
    bit forced, head, alu, byp, was_empty;
    @(negedge clk);
    obs_alu_ready = bus.aluReady; obs_mem_ready = bus.memReady; obs_mask = bus.pendingMask;
    alu_e = '{reg_idx: bus.aluReg, data: bus.aluData};
    mem_e = '{reg_idx: bus.memReg, data: bus.memData};
    was_empty   = (q.size() == 0);
    forced      = !was_empty && (starve == SL);
    m_alu_ready = !forced;
    m_mem_ready = q.size() < FD;
    m_mask      = '0;
    foreach (q[i]) m_mask[q[i].reg_idx] = 1'b1;
    m_alu_acc = bus.aluValid && m_alu_ready;
    m_mem_acc = bus.memValid && m_mem_ready;
    head = forced || (!m_alu_acc && !was_empty);
    alu  = !forced && m_alu_acc;
    byp  = was_empty && !m_alu_acc && m_mem_acc;
    @(posedge clk); #1;
    m_wr = head || alu || byp;
    if (head) begin
      e = q.pop_front(); m_reg = e.reg_idx; m_data = e.data;
    end else if (alu) begin
      m_reg = alu_e.reg_idx; m_data = alu_e.data;
    end else if (byp) begin
      m_reg = mem_e.reg_idx; m_data = mem_e.data;
    end
    if (m_mem_acc && !byp) q.push_back(mem_e);
    if (head || was_empty) starve = 0;
    else if (m_alu_acc) starve++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
      @(negedge clk);
      total++;
      if ({bus.regWrEn, bus.regToWrite, bus.dataIn, bus.pendingMask, bus.memReady, bus.aluReady}
          !== {1'b0, 2'd0, 8'd0, 4'd0, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL reset_state: got wr=%b reg=%0d data=%h mask=%b mr=%b ar=%b want 0 0 00 0000 1 1",
                 bus.regWrEn, bus.regToWrite, bus.dataIn, bus.pendingMask, bus.memReady,
                 bus.aluReady);
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_write();
    set_in(1, 2'd1, 8'hFE, 0, 0, 0);
    cycle();
    total++;
    if ({bus.regWrEn, bus.regToWrite, bus.dataIn} !== {1'b1, 2'd1, 8'hFE}) begin
      bad++;
      $display("FAIL alu_write: got %b/%0d/%h want 1/1/fe", bus.regWrEn, bus.regToWrite, bus.dataIn);
    end
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    total++;
    if ({bus.regWrEn, bus.regToWrite, bus.dataIn} !== {1'b0, 2'd1, 8'hFE}) begin
      bad++;
      $display("FAIL idle_hold: got %b/%0d/%h want 0/1/fe", bus.regWrEn, bus.regToWrite, bus.dataIn);
    end
  endtask

  task automatic test_bypass();
    set_in(0, 0, 0, 1, 2'd3, 8'hFA);
    cycle();
    total++;
    if ({obs_mask, bus.regWrEn, bus.regToWrite, bus.dataIn} !== {4'd0, 1'b1, 2'd3, 8'hFA}) begin
      bad++;
      $display("FAIL bypass: got mask=%b %b/%0d/%h want 0000 1/3/fa", obs_mask, bus.regWrEn,
               bus.regToWrite, bus.dataIn);
    end
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    total++;
    if ({obs_mask, bus.regWrEn} !== 5'b0) begin
      bad++;
      $display("FAIL bypass_after: got mask=%b wr=%b want 0000 0", obs_mask, bus.regWrEn);
    end
  endtask

  task automatic test_conflict();
    set_in(1, 2'd0, 8'h55, 1, 2'd2, 8'h11);
    cycle();
    total++;
    if ({bus.regWrEn, bus.regToWrite, bus.dataIn} !== {1'b1, 2'd0, 8'h55}) begin
      bad++;
      $display("FAIL conflict_alu_first: got %b/%0d/%h want 1/0/55", bus.regWrEn, bus.regToWrite,
               bus.dataIn);
    end
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
    total++;
    if ({obs_mask, bus.regWrEn, bus.regToWrite, bus.dataIn} !== {4'b0100, 1'b1, 2'd2, 8'h11}) begin
      bad++;
      $display("FAIL conflict_load: got mask=%b %b/%0d/%h want 0100 1/2/11", obs_mask,
               bus.regWrEn, bus.regToWrite, bus.dataIn);
    end
    cycle();
  endtask

  task automatic test_starvation();
    int n = 0;
    bit done = 0;
    set_in(1, 2'd0, 8'h20, 1, 2'd1, 8'h77);
    cycle();
    for (int i = 0; i < 10 && !done; i++) begin
      set_in(1, 2'd0, 8'(8'h21 + i), 0, 0, 0);
      cycle();
      if (obs_alu_ready) n++;
      else begin
        done = 1;
        total++;
        if ({bus.regWrEn, bus.regToWrite, bus.dataIn} !== {1'b1, 2'd1, 8'h77}) begin
          bad++;
          $display("FAIL starve_drain: got %b/%0d/%h want 1/1/77", bus.regWrEn, bus.regToWrite,
                   bus.dataIn);
        end
      end
    end
    total++;
    if (!done || n != SL) begin
      bad++;
      $display("FAIL starve_count: got %0d alu wins (drained=%0d) want %0d", n, done, SL);
    end
    set_in(1, 2'd3, 8'h3C, 0, 0, 0);
    cycle();
    total++;
    if ({obs_alu_ready, bus.regWrEn, bus.regToWrite, bus.dataIn} !== {1'b1, 1'b1, 2'd3, 8'h3C}) begin
      bad++;
      $display("FAIL starve_clear: got ar=%b %b/%0d/%h want 1 1/3/3c", obs_alu_ready,
               bus.regWrEn, bus.regToWrite, bus.dataIn);
    end
    set_in(0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_full();
    logic [1:0] lr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] got [$];
    int idx = 0;
    bit saw_full = 0;
    for (int c = 0; c < 40 && got.size() < 5; c++) begin
      set_in(idx < 5, 2'd1, 8'(c), idx < 5, idx < 5 ? lr[idx] : 2'd0, 8'(8'hA0 + idx));
      cycle();
      if (bus.memValid && !obs_mem_ready) saw_full = 1;
      if (bus.memValid && obs_mem_ready) idx++;
      if (bus.regWrEn && bus.dataIn[7:4] == 4'hA) got.push_back(bus.dataIn);
      total++;
      if ({bus.regWrEn, bus.regToWrite, bus.dataIn, obs_mem_ready, obs_mask}
          !== {m_wr, m_reg, m_data, m_mem_ready, m_mask}) begin
        bad++;
        $display("FAIL full_model: cycle %0d got %b/%0d/%h mr=%b mask=%b want %b/%0d/%h mr=%b mask=%b",
                 c, bus.regWrEn, bus.regToWrite, bus.dataIn, obs_mem_ready, obs_mask, m_wr, m_reg,
                 m_data, m_mem_ready, m_mask);
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
    total++;
    if (!saw_full) begin
      bad++;
      $display("FAIL full_backpressure: got memReady never low want low with 4 buffered");
    end
    total++;
    if (got.size() != 5 || got[0] != 8'hA0 || got[1] != 8'hA1 || got[2] != 8'hA2 ||
        got[3] != 8'hA3 || got[4] != 8'hA4) begin
      bad++;
      $display("FAIL full_order: got %p want a0 a1 a2 a3 a4", got);
    end
  endtask

  task automatic test_reset_mid();
    set_in(1, 2'd0, 8'h01, 1, 2'd1, 8'hB1);
    cycle();
    set_in(1, 2'd0, 8'h02, 1, 2'd3, 8'hB3);
    cycle();
    total++;
    if (bus.pendingMask !== 4'b1010) begin
      bad++;
      $display("FAIL mid_pending: got %b want 1010", bus.pendingMask);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.regWrEn, bus.regToWrite, bus.dataIn, bus.pendingMask, bus.memReady, bus.aluReady}
        !== {1'b0, 2'd0, 8'd0, 4'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset: got %b/%0d/%h mask=%b mr=%b ar=%b want 0/0/00 0000 1 1",
               bus.regWrEn, bus.regToWrite, bus.dataIn, bus.pendingMask, bus.memReady,
               bus.aluReady);
    end
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if ({bus.regWrEn, obs_mask} !== 5'b0) begin
        bad++;
        $display("FAIL mid_no_stale: got wr=%b mask=%b want 0 0000", bus.regWrEn, obs_mask);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!bus.aluValid || m_alu_acc) begin
        bus.aluValid = ($urandom_range(0, 9) < 6);
        bus.aluReg = 2'($urandom); bus.aluData = 8'($urandom);
      end
      if (!bus.memValid || m_mem_acc) begin
        bus.memValid = ($urandom_range(0, 9) < 5);
        bus.memReg = 2'($urandom); bus.memData = 8'($urandom);
      end
      cycle();
      total++;
      if ({bus.regWrEn, bus.regToWrite, bus.dataIn, obs_alu_ready, obs_mem_ready, obs_mask}
          !== {m_wr, m_reg, m_data, m_alu_ready, m_mem_ready, m_mask}) begin
        bad++;
        $display("FAIL random: cycle %0d got %b/%0d/%h ar=%b mr=%b mask=%b want %b/%0d/%h ar=%b mr=%b mask=%b",
                 c, bus.regWrEn, bus.regToWrite, bus.dataIn, obs_alu_ready, obs_mem_ready,
                 obs_mask, m_wr, m_reg, m_data, m_alu_ready, m_mem_ready, m_mask);
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    m_alu_acc = 0; m_mem_acc = 0;
    model_reset();
    test_reset();
    test_alu_write();
    test_bypass();
    test_conflict();
    test_starvation();
    test_full();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
